// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for an 8-deep synchronous FIFO: pops words, absorbs the
// FIFO's registered read latency in a 2-entry buffer and serves a valid/ready stream.
module fifo_rd_ctrl #(
  parameter int DWIDTH = 8,
  parameter int CNTW   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [DWIDTH-1:0] fifo_dout,
  output logic              fifo_rd,
  output logic              m_valid,
  output logic [DWIDTH-1:0] m_data,
  input  logic              m_ready,
  input  logic              flush,
  output logic [CNTW-1:0]   word_cnt
);

  logic [1:0]        occ_q, occ_d;
  logic              inflight_q, inflight_d;
  logic [DWIDTH-1:0] buf0_q, buf0_d;
  logic [DWIDTH-1:0] buf1_q, buf1_d;
  logic [CNTW-1:0]   word_cnt_q, word_cnt_d;

  logic              xfer;
  logic [1:0]        occ_after_pop;
  logic [2:0]        occ_sum;

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    m_valid       = (occ_q != 2'd0) & ~flush;
    xfer          = m_valid & m_ready;
    occ_sum       = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, xfer};
    occ_after_pop = occ_q - {1'b0, xfer};

    // m_ready feeds fifo_rd combinationally so a pop can refill the slot freed this cycle.
    fifo_rd    = ~rst & ~flush & ~fifo_empty & (occ_sum < 3'd2);
    inflight_d = fifo_rd & ~fifo_empty & ~flush;

    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    occ_d      = occ_sum[1:0];
    word_cnt_d = word_cnt_q + CNTW'(xfer);

    if (xfer) begin
      buf0_d = buf1_q;
    end

    // The arriving word lands in the first slot still free after this cycle's pop.
    if (inflight_q) begin
      if (occ_after_pop == 2'd0) begin
        buf0_d = fifo_dout;
      end else begin
        buf1_d = fifo_dout;
      end
    end

    if (flush) begin
      occ_d  = 2'd0;
      buf0_d = buf0_q;
      buf1_d = buf1_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      // NOTE: the data buffers are reset too, because m_data must read 0 out of reset.
      buf0_q     <= '0;
      buf1_q     <= '0;
      word_cnt_q <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  // The read-issue rule bounds occupancy at 2; reaching 3 would mean a lost word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (occ_sum <= 3'd2);
    end
  end

  assign m_data   = buf0_q;
  assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: table vectors, directed corner sequences and
// random traffic compared against a queue-based model of the buffered stream.
module tb_fifo_rd_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_dout = 8'h00;
  logic        fifo_rd;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_ready = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] word_cnt;

  logic        w_rd, w_valid;
  logic [7:0]  w_data;
  logic [3:0]  w_cnt;

  fifo_rd_ctrl #(.DWIDTH(8), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd(fifo_rd), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .flush(flush), .word_cnt(word_cnt)
  );

  fifo_rd_ctrl #(.DWIDTH(8), .CNTW(4)) dut_wrap (
    .clk(clk), .rst(rst), .fifo_empty(1'b0), .fifo_dout(8'h5A),
    .fifo_rd(w_rd), .m_valid(w_valid), .m_data(w_data), .m_ready(1'b1),
    .flush(1'b0), .word_cnt(w_cnt)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_checks = 0;

  // Environment FIFO contents and the model of words held by the block
  int fifoq[$];
  int bq[$];
  bit infl = 1'b0;
  int infl_word = 0;
  int exp_cnt = 0;
  bit head_known = 1'b1;
  int head = 0;
  int got[$];
  int pops = 0;

  logic        s_rd, s_valid;
  logic [7:0]  s_data;
  logic [15:0] s_cnt;

  typedef struct {
    bit         rdy;
    bit         exp_rd;
    bit         exp_valid;
    logic [7:0] exp_data;
    int         exp_cnt;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // One clock cycle: drive at negedge, sample and compare, advance the model, step the FIFO.
  task automatic cycle(input bit r, input bit f, input bit rdy, input bit chk);
    bit ev, ex, er, pop;
    rst = r;
    flush = f;
    m_ready = rdy;
    fifo_empty = (fifoq.size() == 0);
    #1;
    s_rd = fifo_rd;
    s_valid = m_valid;
    s_data = m_data;
    s_cnt = word_cnt;
    ev = (bq.size() != 0) && !f;
    ex = ev && rdy;
    er = !r && !f && (fifoq.size() != 0) && (bq.size() + int'(infl) - int'(ex) < 2);
    if (chk) begin
      check("fifo_rd", {31'd0, s_rd}, {31'd0, er});
      check("m_valid", {31'd0, s_valid}, {31'd0, ev});
      if (ev) check("m_data", {24'd0, s_data}, bq[0]);
      else if (head_known) check("m_data_idle", {24'd0, s_data}, head);
      check("word_cnt", {16'd0, s_cnt}, exp_cnt & 32'hFFFF);
    end
    if (s_valid && rdy && !r) got.push_back(int'(s_data));
    pop = s_rd && (fifoq.size() != 0);
    if (pop) pops++;
    if (ex) begin
      void'(bq.pop_front());
      exp_cnt++;
    end
    if (infl && !f) begin
      bq.push_back(infl_word);
      head_known = 1'b0;
    end
    if (f) begin
      bq.delete();
      head_known = 1'b0;
    end
    if (er) infl_word = fifoq[0];
    infl = er;
    if (r) begin
      bq.delete();
      infl = 1'b0;
      exp_cnt = 0;
      head_known = 1'b1;
      head = 0;
    end
    @(posedge clk);
    #1;
    if (pop) fifo_dout = 8'(fifoq.pop_front());
    @(negedge clk);
  endtask

  initial begin
    vec_t tv[5];
    int first_x, last_x, c0, nxt, sent_n;
    int sent[$];

    @(negedge clk);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);

    // Single word: latency and one-shot read strobe, from a vector table
    tv[0] = '{1'b1, 1'b1, 1'b0, 8'h00, 0};
    tv[1] = '{1'b1, 1'b0, 1'b0, 8'h00, 0};
    tv[2] = '{1'b1, 1'b0, 1'b1, 8'hA5, 0};
    tv[3] = '{1'b1, 1'b0, 1'b0, 8'h00, 1};
    tv[4] = '{1'b0, 1'b0, 1'b0, 8'h00, 1};
    fifoq.push_back(8'hA5);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, tv[i].rdy, 1'b1);
      check("tv_rd", {31'd0, s_rd}, {31'd0, tv[i].exp_rd});
      check("tv_valid", {31'd0, s_valid}, {31'd0, tv[i].exp_valid});
      if (tv[i].exp_valid) check("tv_data", {24'd0, s_data}, {24'd0, tv[i].exp_data});
      check("tv_cnt", {16'd0, s_cnt}, tv[i].exp_cnt);
    end

    // Streaming 0x01..0x08 with ready held high
    got.delete();
    for (int v = 1; v <= 8; v++) fifoq.push_back(v);
    first_x = -1;
    last_x = -1;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b1);
      if (s_valid) begin
        if (first_x < 0) first_x = i;
        last_x = i;
      end
    end
    check("stream_len", got.size(), 8);
    for (int i = 0; i < got.size() && i < 8; i++) check("stream_word", got[i], i + 1);
    check("stream_nogap", last_x - first_x, 7);
    check("stream_cnt", {16'd0, word_cnt}, 9);

    // Backpressure: at most two pops while stalled, then an in-order drain
    got.delete();
    pops = 0;
    for (int v = 1; v <= 8; v++) fifoq.push_back(v);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("bp_pops", pops, 2);
    check("bp_hold", {24'd0, s_data}, 1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    check("bp_boundary_rd", {31'd0, s_rd}, 1);
    for (int i = 0; i < 40 && got.size() < 8; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1);
    check("bp_len", got.size(), 8);
    for (int i = 0; i < got.size() && i < 8; i++) check("bp_word", got[i], i + 1);

    // Random traffic and random ready against the pushed sequence
    got.delete();
    sent.delete();
    sent_n = 0;
    c0 = exp_cnt;
    for (int i = 0; i < 4000 && got.size() < 200; i++) begin
      if (sent_n < 200 && fifoq.size() < 8 && $urandom_range(0, 3) != 0) begin
        nxt = int'($urandom_range(0, 255));
        fifoq.push_back(nxt);
        sent.push_back(nxt);
        sent_n++;
      end
      cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
    end
    check("rand_len", got.size(), 200);
    for (int i = 0; i < got.size() && i < sent.size(); i++) check("rand_word", got[i], sent[i]);
    check("rand_cnt", {16'd0, word_cnt}, (c0 + 200) & 32'hFFFF);

    // Flush with a full buffer: the next word out is the next FIFO entry
    for (int v = 8'h11; v <= 8'h18; v++) fifoq.push_back(v);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    c0 = exp_cnt;
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    check("flush_rd", {31'd0, s_rd}, 0);
    check("flush_valid", {31'd0, s_valid}, 0);
    got.delete();
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    check("post_flush_valid", {31'd0, s_valid}, 0);
    for (int i = 0; i < 20 && got.size() < 6; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1);
    check("flush_len", got.size(), 6);
    if (got.size() > 0) check("flush_next", got[0], 8'h13);
    check("flush_cnt", {16'd0, word_cnt}, (c0 + 6) & 32'hFFFF);

    // Flush while a word is in flight during streaming
    for (int v = 8'h21; v <= 8'h28; v++) fifoq.push_back(v);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1);
    nxt = fifoq[0];
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    got.delete();
    for (int i = 0; i < 20 && fifoq.size() + bq.size() > 0; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1);
    check("flush2_has_data", {31'd0, got.size() > 0}, 1);
    if (got.size() > 0) check("flush2_next", got[0], nxt);

    // Reset in mid-stream
    for (int v = 8'h31; v <= 8'h38; v++) fifoq.push_back(v);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 1'b1);
    check("rst_rd", {31'd0, s_rd}, 0);
    check("rst_valid", {31'd0, s_valid}, 0);
    check("rst_data", {24'd0, s_data}, 0);
    check("rst_cnt", {16'd0, s_cnt}, 0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    check("rst_first_pop", {31'd0, s_rd}, 1);
    for (int i = 0; i < 20 && fifoq.size() + bq.size() > 0; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1);

    // Counter wrap on the 4-bit instance: 17 transfers leave word_cnt at 1
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 19; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("wrap_cnt", {28'd0, w_cnt}, 1);
    check("wrap_valid", {31'd0, w_valid}, 1);
    check("wrap_rd", {31'd0, w_rd}, 1);
    check("wrap_data", {24'd0, w_data}, 8'h5A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
